// File: rtl/key_event_queue.sv
// key_event_queue: synchronizes and debounces a raw keyboard keycode, turns new
// presses of the five game keys into events, queues them, and presents one event
// per video frame, aligned to the vertical-sync rising edge.
//
// Ports:
//   pixel_clk    in   pixel clock, the only clock
//   Reset_n      in   asynchronous active-low reset
//   keycode_raw  in   raw 8-bit keycode, asynchronous to pixel_clk
//   vs           in   vertical sync, synchronous to pixel_clk
//   flush        in   synchronous clear of queue and presented key
//   keycode      out  presented keycode, 0 when none
//   lane         out  one-hot lane of keycode (D,F,Space,J,K), 0 when none
//   key_valid    out  high while keycode is nonzero
//   overflow     out  sticky: an event was dropped on a full queue
//   fifo_count   out  number of queued events
module key_event_queue #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned STABLE_CYCLES = 8,
  parameter int unsigned HOLD_FRAMES   = 1
) (
  input  logic                         pixel_clk,
  input  logic                         Reset_n,
  input  logic [7:0]                   keycode_raw,
  input  logic                         vs,
  input  logic                         flush,
  output logic [7:0]                   keycode,
  output logic [4:0]                   lane,
  output logic                         key_valid,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [7:0] STAB_MAX  = 8'(STABLE_CYCLES - 1);
  localparam logic [3:0] HOLD_INIT = 4'(HOLD_FRAMES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_F     = 8'h09;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_J     = 8'h0D;
  localparam logic [7:0] KEY_K     = 8'h0E;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;

  function automatic logic is_game(input logic [7:0] code);
    return (code == KEY_D) || (code == KEY_F) || (code == KEY_SPACE) ||
           (code == KEY_J) || (code == KEY_K);
  endfunction

  // Synchronizer and debounce state
  logic [7:0] sync1_q, sync2_q;
  logic [7:0] cand_q, prev_key_q;
  logic [7:0] stab_cnt_q;
  logic       done_q;       // current cand already accepted
  logic       accept_c;
  logic       push_c;

  // Queue state
  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q;
  logic          full_c, push_ok_c, drop_c;

  // Presentation state
  logic       vs_d_q;
  logic       frame_edge_c;
  logic [0:0] state_q, state_d;
  logic [7:0] key_q, key_d;
  logic [3:0] hold_q, hold_d;
  logic       pop_c;

  // Accept once per new value after STABLE_CYCLES identical samples
  assign accept_c = (sync2_q == cand_q) && (stab_cnt_q == STAB_MAX) && !done_q;
  assign push_c   = accept_c && is_game(cand_q) && (cand_q != prev_key_q);

  always_ff @(posedge pixel_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q    <= 8'h00;
      sync2_q    <= 8'h00;
      cand_q     <= 8'h00;
      stab_cnt_q <= 8'h00;
      done_q     <= 1'b0;
      prev_key_q <= 8'h00;
    end else begin
      sync1_q <= keycode_raw;
      sync2_q <= sync1_q;
      if (sync2_q != cand_q) begin
        cand_q     <= sync2_q;
        stab_cnt_q <= 8'h00;
        done_q     <= 1'b0;
      end else if (stab_cnt_q != STAB_MAX) begin
        stab_cnt_q <= stab_cnt_q + 8'd1;
      end else if (accept_c) begin
        done_q     <= 1'b1;
        prev_key_q <= cand_q;
      end
    end
  end

  // Queue control: flush wins over push; a pop frees the slot for a push on full
  assign full_c    = (count_q == FULL_CNT);
  assign push_ok_c = push_c && !flush && (!full_c || pop_c);
  assign drop_c    = push_c && !flush && full_c && !pop_c;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({push_ok_c, pop_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge pixel_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (drop_c) ovf_q <= 1'b1;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_ok_c) begin
          mem_q[wr_ptr_q] <= cand_q;
          wr_ptr_q        <= wr_ptr_q + PW'(1);
        end
        if (pop_c) rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  assign frame_edge_c = vs && !vs_d_q;

  // Presentation next-state: pop only from entries queued before this cycle
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    hold_d  = hold_q;
    pop_c   = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      key_d   = 8'h00;
      hold_d  = 4'h0;
    end else if (frame_edge_c) begin
      case (state_q)
        ST_IDLE: begin
          if (count_q != '0) begin
            pop_c   = 1'b1;
            key_d   = mem_q[rd_ptr_q];
            hold_d  = HOLD_INIT;
            state_d = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (hold_q != 4'h0) begin
            hold_d = hold_q - 4'd1;
          end else if (count_q != '0) begin
            pop_c  = 1'b1;
            key_d  = mem_q[rd_ptr_q];
            hold_d = HOLD_INIT;
          end else begin
            key_d   = 8'h00;
            state_d = ST_IDLE;
          end
        end
        default: begin
          key_d   = 8'h00;
          hold_d  = 4'h0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge pixel_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_d_q  <= 1'b0;
      state_q <= ST_IDLE;
      key_q   <= 8'h00;
      hold_q  <= 4'h0;
    end else begin
      vs_d_q  <= vs;
      state_q <= state_d;
      key_q   <= key_d;
      hold_q  <= hold_d;
    end
  end

  // Lane is a pure decode of the registered keycode
  always_comb begin
    lane = 5'b00000;
    case (key_q)
      KEY_D:     lane = 5'b00001;
      KEY_F:     lane = 5'b00010;
      KEY_SPACE: lane = 5'b00100;
      KEY_J:     lane = 5'b01000;
      KEY_K:     lane = 5'b10000;
      default:   lane = 5'b00000;
    endcase
  end

  assign keycode    = key_q;
  assign key_valid  = (key_q != 8'h00);
  assign overflow   = ovf_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Testbench for key_event_queue: scoreboard of expected presented keycodes,
// filled as key presses are driven and drained at each frame edge.
module tb_key_event_queue;

  logic       clk;
  logic       rst_n;
  logic [7:0] raw, raw2;
  logic       vs, vs2;
  logic       flush, flush2;
  logic [7:0] keycode, keycode2;
  logic [4:0] lane, lane2;
  logic       key_valid, key_valid2;
  logic       overflow, overflow2;
  logic [2:0] fifo_count, fifo_count2;

  key_event_queue #(.DEPTH(4), .STABLE_CYCLES(8), .HOLD_FRAMES(1)) dut (
    .pixel_clk(clk), .Reset_n(rst_n), .keycode_raw(raw), .vs(vs), .flush(flush),
    .keycode(keycode), .lane(lane), .key_valid(key_valid), .overflow(overflow),
    .fifo_count(fifo_count)
  );

  key_event_queue #(.DEPTH(4), .STABLE_CYCLES(8), .HOLD_FRAMES(2)) dut2 (
    .pixel_clk(clk), .Reset_n(rst_n), .keycode_raw(raw2), .vs(vs2), .flush(flush2),
    .keycode(keycode2), .lane(lane2), .key_valid(key_valid2), .overflow(overflow2),
    .fifo_count(fifo_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  logic [7:0] m_prev;
  logic       m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic is_game(input logic [7:0] c);
    return (c == 8'h07) || (c == 8'h09) || (c == 8'h2C) || (c == 8'h0D) || (c == 8'h0E);
  endfunction

  function automatic logic [4:0] lane_of(input logic [7:0] c);
    case (c)
      8'h07:   return 5'b00001;
      8'h09:   return 5'b00010;
      8'h2C:   return 5'b00100;
      8'h0D:   return 5'b01000;
      8'h0E:   return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  // Drive a stable keycode long enough to be accepted; record the expected event
  task automatic press(input logic [7:0] code);
    raw = code;
    repeat (20) @(negedge clk);
    if (is_game(code) && code != m_prev) begin
      if (exp_q.size() < 4) exp_q.push_back(code);
      else m_ovf = 1'b1;
    end
    m_prev = code;
  endtask

  // One vs pulse, then compare the presented key with the scoreboard head
  task automatic frame_chk(input string tag);
    logic [7:0] e;
    vs = 1'b1;
    @(negedge clk);
    vs = 1'b0;
    repeat (3) @(negedge clk);
    e = 8'h00;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check_eq({tag, ".key"},   32'(keycode),    32'(e));
    check_eq({tag, ".lane"},  32'(lane),       32'(lane_of(e)));
    check_eq({tag, ".valid"}, 32'(key_valid),  32'(e != 8'h00));
    check_eq({tag, ".count"}, 32'(fifo_count), 32'(exp_q.size()));
  endtask

  initial begin
    logic [7:0] seq[6];
    logic [7:0] q2[$];
    logic [7:0] exp2[$];

    rst_n = 1'b0; raw = 8'h00; raw2 = 8'h00;
    vs = 1'b0; vs2 = 1'b0; flush = 1'b0; flush2 = 1'b0;
    m_prev = 8'h00; m_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst.key",   32'(keycode),    32'h0);
    check_eq("rst.lane",  32'(lane),       32'h0);
    check_eq("rst.valid", 32'(key_valid),  32'h0);
    check_eq("rst.ovf",   32'(overflow),   32'h0);
    check_eq("rst.count", 32'(fifo_count), 32'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Single press presented for one frame
    press(8'h07);
    check_eq("t1.count", 32'(fifo_count), 32'(exp_q.size()));
    frame_chk("t1.f1");
    frame_chk("t1.f2");

    // Short glitch never queues
    press(8'h00);
    raw = 8'h0E;
    repeat (5) @(negedge clk);
    raw = 8'h00;
    repeat (20) @(negedge clk);
    check_eq("t2.count", 32'(fifo_count), 32'h0);
    frame_chk("t2.f1");

    // Six presses into a four-deep queue
    seq[0] = 8'h09; seq[1] = 8'h2C; seq[2] = 8'h0D;
    seq[3] = 8'h0E; seq[4] = 8'h07; seq[5] = 8'h09;
    foreach (seq[i]) press(seq[i]);
    check_eq("t3.count", 32'(fifo_count), 32'(exp_q.size()));
    check_eq("t3.ovf",   32'(overflow),   32'(m_ovf));
    for (int i = 0; i < 5; i++) frame_chk($sformatf("t3.f%0d", i));

    // Held key is one event; non-game code never presented
    press(8'h00);
    press(8'h0D);
    for (int i = 0; i < 3; i++) frame_chk($sformatf("t4.f%0d", i));
    press(8'h04);
    frame_chk("t4.nongame");
    check_eq("t4.ovf", 32'(overflow), 32'(m_ovf));

    // Flush while showing with two queued and a push landing in the same cycle
    press(8'h00);
    press(8'h07);
    press(8'h09);
    press(8'h0D);
    frame_chk("t6.show");
    raw = 8'h0E;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    exp_q.delete();
    m_prev = 8'h0E;
    check_eq("t6.flush.key",   32'(keycode),    32'h0);
    check_eq("t6.flush.valid", 32'(key_valid),  32'h0);
    check_eq("t6.flush.count", 32'(fifo_count), 32'h0);
    check_eq("t6.flush.ovf",   32'(overflow),   32'(m_ovf));
    repeat (20) @(negedge clk);
    frame_chk("t6.after");

    // Asynchronous reset mid-frame with a key shown and one queued
    press(8'h00);
    press(8'h07);
    press(8'h09);
    frame_chk("t6.pre_rst");
    #2;
    rst_n = 1'b0;
    raw = 8'h00;
    #1;
    check_eq("t6.arst.key",   32'(keycode),    32'h0);
    check_eq("t6.arst.lane",  32'(lane),       32'h0);
    check_eq("t6.arst.valid", 32'(key_valid),  32'h0);
    check_eq("t6.arst.count", 32'(fifo_count), 32'h0);
    check_eq("t6.arst.ovf",   32'(overflow),   32'h0);
    exp_q.delete();
    m_prev = 8'h00;
    m_ovf  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // HOLD_FRAMES=2 instance: each event spans two frames
    raw2 = 8'h07; repeat (20) @(negedge clk); q2.push_back(8'h07);
    raw2 = 8'h09; repeat (20) @(negedge clk); q2.push_back(8'h09);
    raw2 = 8'h00; repeat (20) @(negedge clk);
    check_eq("t5.count", 32'(fifo_count2), 32'(q2.size()));
    while (q2.size() > 0) begin
      logic [7:0] e;
      e = q2.pop_front();
      exp2.push_back(e);
      exp2.push_back(e);
    end
    exp2.push_back(8'h00);
    foreach (exp2[i]) begin
      vs2 = 1'b1;
      @(negedge clk);
      vs2 = 1'b0;
      repeat (3) @(negedge clk);
      check_eq($sformatf("t5.f%0d.key", i),   32'(keycode2),   32'(exp2[i]));
      check_eq($sformatf("t5.f%0d.lane", i),  32'(lane2),      32'(lane_of(exp2[i])));
      check_eq($sformatf("t5.f%0d.valid", i), 32'(key_valid2), 32'(exp2[i] != 8'h00));
    end
    check_eq("t5.count_end", 32'(fifo_count2), 32'h0);
    check_eq("t5.ovf",       32'(overflow2),   32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
